layer1_fetch_sequencer: RTL and testbench
=========================================

Name: layer1_fetch_sequencer

Overview:
- Downstream neighbour of the accelerator controller.
- Starts once the layer-1 pixel, weight and bias local memories are loaded (all three store_done flags high) and software issues start.
- Reads the 8 biases and 216 weights out once as a parameter stream, then walks the 32x32x3 input image and streams the 3x3x3 window of every output position to the convolution datapath, with valid/ready backpressure.

Parameters:
IMG_W, 32, input width in pixels
IMG_H, 32, input height in pixels
IN_CH, 3, input channels
K, 3, kernel size
OUT_CH, 8, output channels (bias count)
DATA_W, 16, memory data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle start request
layer1_input_store_done  in  1  pixel memory loaded
layer1_weight_store_done  in  1  weight memory loaded
layer1_bias_store_done  in  1  bias memory loaded
read_pixel_mem  out  1  pixel memory read enable
pixel_mem_addr  out  16  pixel read address
pixel_mem_rdata  in  16  pixel read data, valid one cycle after read
read_weight_mem  out  1  weight read enable
weight_mem_addr  out  16  weight read address
weight_mem_rdata  in  16  weight read data, valid one cycle after read
read_bias_mem  out  1  bias read enable
bias_mem_addr  out  16  bias read address
bias_mem_rdata  in  16  bias read data, valid one cycle after read
param_valid  out  1  parameter beat valid (no backpressure)
param_is_bias  out  1  1 = bias beat, 0 = weight beat
param_index  out  8  bias index 0..7 or weight index 0..215
param_data  out  16  parameter value
px_valid  out  1  window pixel valid
px_ready  in  1  datapath accepts pixel
px_data  out  16  window pixel value
px_last  out  1  last (27th) tap of the window
out_row  out  6  output row of the current window
out_col  out  6  output column of the current window
busy  out  1  high from accepted start until done
fetch_done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0; 2-entry skid FIFO empty; in-flight read data discarded. Reset mid-operation aborts without a done pulse.
- Memory layout:
  - Pixel address = (row*IMG_W+col)*IN_CH+ch.
  - Weight address = oc*27+(kr*K+kc)*IN_CH+ch.
  - Bias address = oc.
  - All memories: read in cycle N, rdata sampled in cycle N+1.
- FSM states:
  - IDLE: start accepted only when all three store_done flags are high; otherwise start is ignored. On accept: busy=1, go to LOAD_BIAS.
  - LOAD_BIAS: read bias 0..7, one per cycle. Each read produces a param beat one cycle later (param_is_bias=1, param_index=oc). After read 7, go to LOAD_WEIGHT.
  - LOAD_WEIGHT: read weights 0..215, one per cycle. Each produces a param beat (param_is_bias=0). After read 215, go to STREAM.
    - Exactly 224 param beats total, contiguous, ending before the first px_valid.
  - STREAM: for out_row 0..IMG_H-K, out_col 0..IMG_W-K, tap order kr, kc, ch (ch fastest), issue a pixel read at address ((out_row+kr)*IMG_W+out_col+kc)*IN_CH+ch.
    - Returned data enters the skid FIFO, which drives px_*.
    - A read is issued only when FIFO occupancy plus in-flight reads < 2.
    - px_data, px_last, out_row and out_col stay stable while px_valid=1 and px_ready=0.
    - Throughput is 1 beat per cycle with px_ready held high.
    - 900 windows x 27 = 24300 beats. px_last=1 on every 27th beat.
  - DRAIN: wait until the FIFO is empty and the final beat is accepted; then fetch_done=1 for one cycle, busy=0, return to IDLE.
- start while busy: ignored.
- store_done flags dropping mid-run: ignored; they are sampled only at start.
- A beat is transferred only in a cycle with px_valid and px_ready both high.
- out_row and out_col belong to the beat, carried through the FIFO alongside px_data.

Optional Feature:
ZERO_PAD_EN
- Defined:
  - Same-padding mode: out_row/out_col span 0..IMG_H-1 / 0..IMG_W-1, i.e. 1024 windows, 27648 beats.
  - Tap input coordinate = out+k-1.
  - Out-of-range taps issue no memory read and push px_data=0 into the FIFO in issue order.
- Undefined: valid convolution only (900 windows), exactly as above.

Test Plan:
1. Reset values: assert rst mid-STREAM -> all outputs 0 immediately; no fetch_done pulse; a later start with all done flags high restarts from bias 0.
2. Start gating: start with layer1_weight_store_done=0 -> busy stays 0, no memory reads; raise the flag and pulse start -> busy=1 next cycle.
3. Parameter stream: full run -> 8 bias beats (index 0..7, bias addresses 0..7), then 216 weight beats (index 0..215), contiguous, before any px_valid.
4. Window order, px_ready=1: first window addresses 0..8, 96..104, 192..200; px_last on beat 27; second window starts at address 3 with out_col=1; fetch_done after exactly 24300 beats, last window out_row=29, out_col=29.
5. Random px_ready: no beat lost or duplicated; outputs stable while stalled; never more than 2 reads outstanding plus buffered; beat sequence identical to scenario 4.
6. ZERO_PAD_EN build: window (0,0) taps with kr=0 or kc=0 emit 0 with no read_pixel_mem; first real read is address 0 at tap (kr=1, kc=1, ch=0); total 27648 beats.

Source files
------------

// File: rtl/layer1_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer1_fetch_sequencer
// Desc     : Streams the layer-1 biases and weights once, then every 3x3x3
//            input window through a 2-entry skid FIFO to the conv datapath.
// Options  : define ZERO_PAD_EN for same-padding (out-of-range taps emit 0).
// Revision : 1.0 - initial release
// ============================================================================
module layer1_fetch_sequencer #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int IN_CH  = 3,
  parameter int K      = 3,
  parameter int OUT_CH = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              layer1_input_store_done,
  input  logic              layer1_weight_store_done,
  input  logic              layer1_bias_store_done,
  output logic              read_pixel_mem,
  output logic [15:0]       pixel_mem_addr,
  input  logic [DATA_W-1:0] pixel_mem_rdata,
  output logic              read_weight_mem,
  output logic [15:0]       weight_mem_addr,
  input  logic [DATA_W-1:0] weight_mem_rdata,
  output logic              read_bias_mem,
  output logic [15:0]       bias_mem_addr,
  input  logic [DATA_W-1:0] bias_mem_rdata,
  output logic              param_valid,
  output logic              param_is_bias,
  output logic [7:0]        param_index,
  output logic [DATA_W-1:0] param_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [DATA_W-1:0] px_data,
  output logic              px_last,
  output logic [5:0]        out_row,
  output logic [5:0]        out_col,
  output logic              busy,
  output logic              fetch_done
);

`ifdef ZERO_PAD_EN
  localparam int c_ROW_LAST = IMG_H - 1;
  localparam int c_COL_LAST = IMG_W - 1;
  localparam int c_PAD      = (K - 1) / 2;
`else
  localparam int c_ROW_LAST = IMG_H - K;
  localparam int c_COL_LAST = IMG_W - K;
  localparam int c_PAD      = 0;
`endif
  localparam int          c_NUM_WEIGHTS = OUT_CH * K * K * IN_CH;
  localparam logic [1:0]  c_K_LAST      = 2'(K - 1);
  localparam logic [1:0]  c_CH_LAST     = 2'(IN_CH - 1);
  localparam logic [5:0]  c_ROW_LAST6   = 6'(c_ROW_LAST);
  localparam logic [5:0]  c_COL_LAST6   = 6'(c_COL_LAST);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_BIAS   = 3'd1,
    S_LOAD_WEIGHT = 3'd2,
    S_STREAM      = 3'd3,
    S_DRAIN       = 3'd4
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [5:0]        row;
    logic [5:0]        col;
  } beat_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [5:0]  r_row, r_col;
  logic [1:0]  r_kr, r_kc, r_ch;
  logic        r_param_valid, r_param_is_bias;
  logic [7:0]  r_param_index;
  logic        r_p_valid, r_p_zero, r_p_last;
  logic [5:0]  r_p_row, r_p_col;
  beat_t       r_fifo [2];
  logic        r_wr_ptr, r_rd_ptr;
  logic [1:0]  r_occ;

  logic        w_all_done, w_issue, w_pop, w_space, w_oob, w_tap_last, w_win_last;
  logic [6:0]  w_in_row, w_in_col;
  logic [15:0] w_pix_addr;
  beat_t       w_head, w_push;

  assign w_all_done = layer1_input_store_done & layer1_weight_store_done &
                      layer1_bias_store_done;

  assign w_in_row   = 7'(r_row) + 7'(r_kr) - 7'(c_PAD);
  assign w_in_col   = 7'(r_col) + 7'(r_kc) - 7'(c_PAD);
  // Negative coordinates wrap to large unsigned values and fail the same test.
  assign w_oob      = (w_in_row >= 7'(IMG_H)) || (w_in_col >= 7'(IMG_W));
  assign w_pix_addr = (16'(w_in_row) * 16'(IMG_W) + 16'(w_in_col)) * 16'(IN_CH) + 16'(r_ch);

  assign w_tap_last = (r_kr == c_K_LAST) && (r_kc == c_K_LAST) && (r_ch == c_CH_LAST);
  assign w_win_last = w_tap_last && (r_row == c_ROW_LAST6) && (r_col == c_COL_LAST6);

  // Issued-but-not-pushed taps count as in flight; a pop this cycle frees a slot.
  assign w_pop      = px_valid & px_ready;
  assign w_space    = ({1'b0, r_occ} + {2'b00, r_p_valid} - {2'b00, w_pop}) < 3'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    read_bias_mem   = 1'b0;
    bias_mem_addr   = 16'd0;
    read_weight_mem = 1'b0;
    weight_mem_addr = 16'd0;
    w_issue         = 1'b0;
    fetch_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_all_done) w_next = S_LOAD_BIAS;
      end
      S_LOAD_BIAS: begin
        read_bias_mem = 1'b1;
        bias_mem_addr = 16'(r_cnt);
        if (r_cnt == 8'(OUT_CH - 1)) w_next = S_LOAD_WEIGHT;
      end
      S_LOAD_WEIGHT: begin
        read_weight_mem = 1'b1;
        weight_mem_addr = 16'(r_cnt);
        if (r_cnt == 8'(c_NUM_WEIGHTS - 1)) w_next = S_STREAM;
      end
      S_STREAM: begin
        w_issue = w_space;
        if (w_issue && w_win_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_p_valid && (r_occ == 2'd0)) begin
          fetch_done = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign read_pixel_mem = w_issue & ~w_oob;
  assign pixel_mem_addr = read_pixel_mem ? w_pix_addr : 16'd0;
  assign busy           = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt           <= 8'd0;
      r_row           <= 6'd0;
      r_col           <= 6'd0;
      r_kr            <= 2'd0;
      r_kc            <= 2'd0;
      r_ch            <= 2'd0;
      r_param_valid   <= 1'b0;
      r_param_is_bias <= 1'b0;
      r_param_index   <= 8'd0;
    end else begin
      r_param_valid   <= read_bias_mem | read_weight_mem;
      r_param_is_bias <= read_bias_mem;
      r_param_index   <= (read_bias_mem | read_weight_mem) ? r_cnt : 8'd0;

      if ((r_state == S_LOAD_BIAS) || (r_state == S_LOAD_WEIGHT))
        r_cnt <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
      else
        r_cnt <= 8'd0;

      if (w_issue) begin
        if (r_ch == c_CH_LAST) begin
          r_ch <= 2'd0;
          if (r_kc == c_K_LAST) begin
            r_kc <= 2'd0;
            if (r_kr == c_K_LAST) begin
              r_kr <= 2'd0;
              if (r_col == c_COL_LAST6) begin
                r_col <= 6'd0;
                r_row <= (r_row == c_ROW_LAST6) ? 6'd0 : r_row + 6'd1;
              end else begin
                r_col <= r_col + 6'd1;
              end
            end else begin
              r_kr <= r_kr + 2'd1;
            end
          end else begin
            r_kc <= r_kc + 2'd1;
          end
        end else begin
          r_ch <= r_ch + 2'd1;
        end
      end
    end
  end

  assign param_valid   = r_param_valid;
  assign param_is_bias = r_param_is_bias;
  assign param_index   = r_param_index;
  assign param_data    = !r_param_valid ? '0 :
                         (r_param_is_bias ? bias_mem_rdata : weight_mem_rdata);

  always_comb begin
    w_push      = '0;
    w_push.data = r_p_zero ? '0 : pixel_mem_rdata;
    w_push.last = r_p_last;
    w_push.row  = r_p_row;
    w_push.col  = r_p_col;
  end

  // Tap side-band rides alongside the memory read so the FIFO entry is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_valid <= 1'b0;
      r_p_zero  <= 1'b0;
      r_p_last  <= 1'b0;
      r_p_row   <= 6'd0;
      r_p_col   <= 6'd0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_occ     <= 2'd0;
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
    end else begin
      r_p_valid <= w_issue;
      if (w_issue) begin
        r_p_zero <= w_oob;
        r_p_last <= w_tap_last;
        r_p_row  <= r_row;
        r_p_col  <= r_col;
      end
      if (r_p_valid) begin
        r_fifo[r_wr_ptr] <= w_push;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, r_p_valid} - {1'b0, w_pop};
    end
  end

  assign w_head   = r_fifo[r_rd_ptr];
  assign px_valid = (r_occ != 2'd0);
  assign px_data  = w_head.data;
  assign px_last  = w_head.last;
  assign out_row  = w_head.row;
  assign out_col  = w_head.col;

endmodule
`default_nettype wire

// File: tb/tb_layer1_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer1_fetch_sequencer
// Desc     : Self-checking bench: start gating table plus full-run sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer1_fetch_sequencer;
  localparam int IMG_W = 32, IMG_H = 32, IN_CH = 3;
`ifdef ZERO_PAD_EN
  localparam int OFS = 1, NROW = 32, NCOL = 32;
`else
  localparam int OFS = 0, NROW = 30, NCOL = 30;
`endif
  localparam int NBEAT = NROW * NCOL * 27;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, px_ready = 1'b0;
  logic in_done = 1'b0, w_done = 1'b0, b_done = 1'b0;
  logic read_pixel_mem, read_weight_mem, read_bias_mem;
  logic [15:0] pixel_mem_addr, weight_mem_addr, bias_mem_addr;
  logic [15:0] pix_rdata = 16'd0, wt_rdata = 16'd0, bias_rdata = 16'd0;
  logic param_valid, param_is_bias, px_valid, px_last, busy, fetch_done;
  logic [7:0]  param_index;
  logic [15:0] param_data, px_data;
  logic [5:0]  out_row, out_col;
  logic        outs_zero;

  int total = 0, bad = 0;

  layer1_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .layer1_input_store_done(in_done), .layer1_weight_store_done(w_done),
    .layer1_bias_store_done(b_done),
    .read_pixel_mem(read_pixel_mem), .pixel_mem_addr(pixel_mem_addr), .pixel_mem_rdata(pix_rdata),
    .read_weight_mem(read_weight_mem), .weight_mem_addr(weight_mem_addr), .weight_mem_rdata(wt_rdata),
    .read_bias_mem(read_bias_mem), .bias_mem_addr(bias_mem_addr), .bias_mem_rdata(bias_rdata),
    .param_valid(param_valid), .param_is_bias(param_is_bias), .param_index(param_index),
    .param_data(param_data), .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .px_last(px_last), .out_row(out_row), .out_col(out_col), .busy(busy), .fetch_done(fetch_done)
  );

  always #5 clk = ~clk;

  assign outs_zero = ~|{read_pixel_mem, pixel_mem_addr, read_weight_mem, weight_mem_addr,
                        read_bias_mem, bias_mem_addr, param_valid, param_is_bias, param_index,
                        param_data, px_valid, px_data, px_last, out_row, out_col, busy, fetch_done};

  function automatic logic [15:0] pix_f(input logic [15:0] a);
    return a * 16'd7 + 16'd3;
  endfunction

  always @(posedge clk) begin
    if (read_pixel_mem)  pix_rdata  <= pix_f(pixel_mem_addr);
    if (read_weight_mem) wt_rdata   <= 16'h1000 + weight_mem_addr;
    if (read_bias_mem)   bias_rdata <= 16'h2000 + bias_mem_addr;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void tap_model(input int k, output int addr, output bit oob,
                                    output int row, output int col, output bit last);
    int w, t, ir, ic;
    w = k / 27; t = k % 27;
    row = w / NCOL; col = w % NCOL;
    ir = row + t / 9 - OFS;
    ic = col + (t / 3) % 3 - OFS;
    oob = (ir < 0) || (ir >= IMG_H) || (ic < 0) || (ic >= IMG_W);
    addr = (ir * IMG_W + ic) * IN_CH + t % 3;
    last = (t == 26);
  endfunction

  task automatic run_full(input bit rnd, input int abort_at);
    int bias_rd = 0, wt_rd = 0, pcnt = 0, p_first = -1, p_last = -1, px_first = -1;
    int rd_k = 0, n_rd = 0, beats = 0, outst = 0, max_out = 0;
    int errs = 0, stall_errs = 0, busy_errs = 0, done_cnt = 0, done_beats = -1;
    int last_pop = -1, last_row = -1, last_col = -1, seen = 0, cnt = 0;
    int ea, er, ec, eidx;
    bit eo, el, stall_prev = 1'b0, finished = 1'b0;
    logic [15:0] rec_addr [32];
    logic [15:0] rec_data [40];
    logic        rec_last [40];
    logic [5:0]  rec_row [40], rec_col [40];
    logic [15:0] h_data, edata;
    logic        h_last;
    logic [5:0]  h_row, h_col;

    @(posedge clk); #1;
    in_done = 1'b1; w_done = 1'b1; b_done = 1'b1; start = 1'b1; px_ready = 1'b0;
    for (int cyc = 0; cyc < 45000 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 40);
      if (cyc == 40) begin in_done = 1'b0; w_done = 1'b0; b_done = 1'b0; end
      px_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      #1;
      if (abort_at > 0 && beats >= abort_at) begin
        rst = 1'b1; #1;
        check("abort_outputs_zero", outs_zero, 1);
        repeat (3) begin
          @(posedge clk); #2;
          if (fetch_done || busy) seen++;
        end
        check("abort_no_done_no_busy", seen, 0);
        rst = 1'b0;
        return;
      end
      if (!busy) busy_errs++;
      if (read_bias_mem) begin
        if (bias_mem_addr != 16'(bias_rd)) errs++;
        bias_rd++;
      end
      if (read_weight_mem) begin
        if (weight_mem_addr != 16'(wt_rd)) errs++;
        wt_rd++;
      end
      if (param_valid) begin
        if (pcnt == 0) p_first = cyc;
        p_last = cyc;
        eidx  = (pcnt < 8) ? pcnt : pcnt - 8;
        edata = (pcnt < 8) ? 16'h2000 + 16'(eidx) : 16'h1000 + 16'(eidx);
        if (param_is_bias != (pcnt < 8) || param_index != 8'(eidx) || param_data != edata) errs++;
        pcnt++;
      end
      if (px_valid && px_first < 0) px_first = cyc;
      if (read_pixel_mem) begin
        tap_model(rd_k, ea, eo, er, ec, el);
        while (eo && rd_k < NBEAT - 1) begin
          rd_k++;
          tap_model(rd_k, ea, eo, er, ec, el);
        end
        if (eo || pixel_mem_addr != 16'(ea)) errs++;
        if (n_rd < 32) rec_addr[n_rd] = pixel_mem_addr;
        n_rd++; rd_k++; outst++;
      end
      if (stall_prev && (!px_valid || px_data != h_data || px_last != h_last ||
                         out_row != h_row || out_col != h_col)) stall_errs++;
      stall_prev = px_valid && !px_ready;
      h_data = px_data; h_last = px_last; h_row = out_row; h_col = out_col;
      if (px_valid && px_ready) begin
        tap_model(beats, ea, eo, er, ec, el);
        edata = eo ? 16'd0 : pix_f(16'(ea));
        if (beats >= NBEAT || px_data != edata || px_last != el ||
            out_row != 6'(er) || out_col != 6'(ec)) errs++;
        if (beats < 40) begin
          rec_data[beats] = px_data; rec_last[beats] = px_last;
          rec_row[beats] = out_row; rec_col[beats] = out_col;
        end
        if (!eo) outst--;
        last_pop = cyc; last_row = int'(out_row); last_col = int'(out_col);
        beats++;
      end
      if (outst > max_out) max_out = outst;
      if (fetch_done) begin
        done_cnt++; done_beats = beats; finished = 1'b1;
      end
    end

    check("done_pulses", done_cnt, 1);
    check("beats_at_done", done_beats, NBEAT);
    check("beat_and_param_errors", errs, 0);
    check("stall_hold_errors", stall_errs, 0);
    check("busy_low_during_run", busy_errs, 0);
    check("max_outstanding_le2", max_out <= 2, 1);
    check("param_beats", pcnt, 224);
    check("param_contiguous", p_last - p_first + 1, pcnt);
    check("param_before_px", px_first > p_last, 1);
    check("bias_reads", bias_rd, 8);
    check("weight_reads", wt_rd, 216);
    check("last_out_row", last_row, NROW - 1);
    check("last_out_col", last_col, NCOL - 1);
    if (!rnd) check("full_throughput", last_pop - px_first + 1, NBEAT);
`ifdef ZERO_PAD_EN
    check("pad_first_read_addr", rec_addr[0], 0);
    check("pad_read1_addr", rec_addr[1], 1);
    check("pad_read3_addr", rec_addr[3], 3);
    check("pad_read6_addr", rec_addr[6], 96);
    for (int i = 0; i < 12; i++) if (rec_data[i] != 16'd0) cnt++;
    check("pad_leading_zero_taps", cnt, 0);
    check("pad_beat12_data", rec_data[12], 3);
    check("pad_beat13_data", rec_data[13], 10);
`else
    check("win0_addr0", rec_addr[0], 0);
    check("win0_addr8", rec_addr[8], 8);
    check("win0_addr9", rec_addr[9], 96);
    check("win0_addr17", rec_addr[17], 104);
    check("win0_addr18", rec_addr[18], 192);
    check("win0_addr26", rec_addr[26], 200);
    check("win1_addr0", rec_addr[27], 3);
`endif
    for (int i = 0; i < 26; i++) if (rec_last[i]) cnt += 100;
    check("no_early_last", cnt % 100 == 0 || cnt < 100, 1);
    check("last_on_beat27", rec_last[26], 1);
    check("win1_out_col", rec_col[27], 1);
    check("win1_out_row", rec_row[27], 0);
    @(posedge clk); #2;
    check("busy_after_done", busy, 0);
    check("done_single_cycle", fetch_done, 0);
  endtask

  typedef struct {
    logic i_d, w_d, b_d, st, exp_busy;
  } gate_vec_t;

  gate_vec_t gv [6];

  initial begin
    gv[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    gv[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    gv[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    gv[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    gv[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    gv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs_zero", outs_zero, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_done = gv[i].i_d; w_done = gv[i].w_d; b_done = gv[i].b_d; start = gv[i].st;
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      check($sformatf("gate%0d_busy", i), busy, gv[i].exp_busy);
      check($sformatf("gate%0d_bias_read", i), read_bias_mem, gv[i].exp_busy);
      check($sformatf("gate%0d_pixel_read", i), read_pixel_mem, 0);
      if (busy) begin
        rst = 1'b1; #1;
        check($sformatf("gate%0d_reset_zero", i), outs_zero, 1);
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end

    run_full(1'b0, 100);
    run_full(1'b0, 0);
    run_full(1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
